// File: rtl/lcd_nibble_receiver_if.sv
// lcd_nibble_receiver_if
//   The 4-bit HD44780-style write bus that runs from an LCD controller to an LCD.
//   master : the controller, which drives E, RS, RW and DB[7:4].
//   slave  : the receiver or monitor, which only observes the bus.
//   iLCD_Enabled         E strobe
//   iLCD_RegisterSelect  0 = command, 1 = data
//   iLCD_ReadWrite       must be 0 (write-only bus)
//   iLCD_Data            nibble on DB[7:4]
interface lcd_nibble_receiver_if;
    logic       iLCD_Enabled;
    logic       iLCD_RegisterSelect;
    logic       iLCD_ReadWrite;
    logic [3:0] iLCD_Data;

    modport master (
        output iLCD_Enabled,
        output iLCD_RegisterSelect,
        output iLCD_ReadWrite,
        output iLCD_Data
    );

    modport slave (
        input iLCD_Enabled,
        input iLCD_RegisterSelect,
        input iLCD_ReadWrite,
        input iLCD_Data
    );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver
//   LCD-side responder for the 4-bit HD44780 write bus.
//   It waits for the power-on sync sequence (3,3,3,2), then pairs nibbles, high nibble first,
//   into command or data bytes. It also checks E strobe timing and the bus protocol.
//
//   Ports:
//     Clock, Reset      rising-edge clock; synchronous active-high reset
//     lcd               bus being observed (slave modport)
//     oByte             last assembled byte {high, low}
//     oByteIsData       RS value of the last assembled byte
//     oByteValid        one-cycle pulse when oByte / oByteIsData update
//     oInitDone         sync sequence has completed (held until Reset)
//     oByteCount        number of bytes accepted, wraps from 255 to 0
//     oTimingError      sticky: E-high time or gap time was too short
//     oSequenceError    sticky: bad sync nibble, RS mismatch inside a pair, or a strobe with RW=1
module lcd_nibble_receiver #(
    parameter int unsigned MIN_E_HIGH = 1,
    parameter int unsigned MIN_GAP    = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    lcd_nibble_receiver_if.slave       lcd,
    output logic [7:0]                 oByte,
    output logic                       oByteIsData,
    output logic                       oByteValid,
    output logic                       oInitDone,
    output logic [7:0]                 oByteCount,
    output logic                       oTimingError,
    output logic                       oSequenceError
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MinEHigh = CNT_W'(MIN_E_HIGH);
    localparam logic [CNT_W-1:0] MinGap   = CNT_W'(MIN_GAP);

    typedef enum logic [2:0] {
        StSync0, StSync1, StSync2, StSync3, StHigh, StLow
    } state_e;

    state_e           state_q, state_d;
    logic             e_q, e_d;
    logic             idle_seen_q, idle_seen_d;     // E has been seen low since reset
    logic             strobe_open_q, strobe_open_d; // a real rise has occurred and E has not yet fallen
    logic             fall_seen_q, fall_seen_d;
    logic             rs_lat_q, rs_lat_d;
    logic             rw_lat_q, rw_lat_d;
    logic [3:0]       db_lat_q, db_lat_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       hi_q, hi_d;
    logic             rs_hi_q, rs_hi_d;
    logic [7:0]       byte_q, byte_d;
    logic             is_data_q, is_data_d;
    logic             valid_q, valid_d;
    logic             init_done_q, init_done_d;
    logic [7:0]       count_q, count_d;
    logic             terr_q, terr_d;
    logic             serr_q, serr_d;

    logic e, rise, fall;

    always_comb begin
        e    = lcd.iLCD_Enabled;
        // If E is already high when reset is released, that high level does not count as a rise.
        // The matching fall is then masked by strobe_open_q.
        rise = e & ~e_q & idle_seen_q;
        fall = ~e & e_q & strobe_open_q;

        e_d           = e;
        idle_seen_d   = idle_seen_q | ~e;
        strobe_open_d = rise ? 1'b1 : (e ? strobe_open_q : 1'b0);
        fall_seen_d   = fall_seen_q | fall;
        rs_lat_d      = e ? lcd.iLCD_RegisterSelect : rs_lat_q;
        rw_lat_d      = e ? lcd.iLCD_ReadWrite      : rw_lat_q;
        db_lat_d      = e ? lcd.iLCD_Data           : db_lat_q;

        // The high count includes the rise cycle itself.
        high_cnt_d = high_cnt_q;
        if (rise)                          high_cnt_d = CntOne;
        else if (e && high_cnt_q != CntMax) high_cnt_d = high_cnt_q + CntOne;

        // The gap count is cleared in the fall cycle, so an E low for only one cycle gives a gap of 0.
        gap_cnt_d = gap_cnt_q;
        if (~e & e_q)                        gap_cnt_d = '0;
        else if (!e && gap_cnt_q != CntMax)  gap_cnt_d = gap_cnt_q + CntOne;

        state_d     = state_q;
        hi_d        = hi_q;
        rs_hi_d     = rs_hi_q;
        byte_d      = byte_q;
        is_data_d   = is_data_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        count_d     = count_q;
        terr_d      = terr_q;
        serr_d      = serr_q;

        if (fall && high_cnt_q < MinEHigh)              terr_d = 1'b1;
        if (rise && fall_seen_q && gap_cnt_q < MinGap) terr_d = 1'b1;

        if (fall) begin
            if (rw_lat_q) begin
                serr_d = 1'b1;
            end else begin
                unique case (state_q)
                    StSync0, StSync1, StSync2: begin
                        if (db_lat_q == 4'h3 && !rs_lat_q) begin
                            state_d = state_e'(state_q + 3'd1);
                        end else begin
                            serr_d  = 1'b1;
                            state_d = StSync0;
                        end
                    end
                    StSync3: begin
                        if (db_lat_q == 4'h2 && !rs_lat_q) begin
                            state_d     = StHigh;
                            init_done_d = 1'b1;
                        end else if (db_lat_q == 4'h3 && !rs_lat_q) begin
                            state_d = StSync3;
                        end else begin
                            serr_d  = 1'b1;
                            state_d = StSync0;
                        end
                    end
                    StHigh: begin
                        hi_d    = db_lat_q;
                        rs_hi_d = rs_lat_q;
                        state_d = StLow;
                    end
                    StLow: begin
                        if (rs_lat_q == rs_hi_q) begin
                            byte_d    = {hi_q, db_lat_q};
                            is_data_d = rs_lat_q;
                            valid_d   = 1'b1;
                            count_d   = count_q + 8'd1;
                        end else begin
                            serr_d = 1'b1;
                        end
                        state_d = StHigh;
                    end
                    default: state_d = StSync0;
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= StSync0;
            e_q           <= 1'b0;
            idle_seen_q   <= 1'b0;
            strobe_open_q <= 1'b0;
            fall_seen_q   <= 1'b0;
            rs_lat_q      <= 1'b0;
            rw_lat_q      <= 1'b0;
            db_lat_q      <= '0;
            high_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            hi_q          <= '0;
            rs_hi_q       <= 1'b0;
            byte_q        <= '0;
            is_data_q     <= 1'b0;
            valid_q       <= 1'b0;
            init_done_q   <= 1'b0;
            count_q       <= '0;
            terr_q        <= 1'b0;
            serr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            e_q           <= e_d;
            idle_seen_q   <= idle_seen_d;
            strobe_open_q <= strobe_open_d;
            fall_seen_q   <= fall_seen_d;
            rs_lat_q      <= rs_lat_d;
            rw_lat_q      <= rw_lat_d;
            db_lat_q      <= db_lat_d;
            high_cnt_q    <= high_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hi_q          <= hi_d;
            rs_hi_q       <= rs_hi_d;
            byte_q        <= byte_d;
            is_data_q     <= is_data_d;
            valid_q       <= valid_d;
            init_done_q   <= init_done_d;
            count_q       <= count_d;
            terr_q        <= terr_d;
            serr_q        <= serr_d;
        end
    end

    assign oByte          = byte_q;
    assign oByteIsData    = is_data_q;
    assign oByteValid     = valid_q;
    assign oInitDone      = init_done_q;
    assign oByteCount     = count_q;
    assign oTimingError   = terr_q;
    assign oSequenceError = serr_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver
//   Directed bench for lcd_nibble_receiver. A table of nibble pairs, each with its expected byte,
//   flags and count, is applied after sync. Hand-written sequences then cover timing, RW, reset
//   and sync corner cases.
module tb_lcd_nibble_receiver;
    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] oByte;
    logic       oByteIsData;
    logic       oByteValid;
    logic       oInitDone;
    logic [7:0] oByteCount;
    logic       oTimingError;
    logic       oSequenceError;

    lcd_nibble_receiver_if bus ();

    lcd_nibble_receiver #(
        .MIN_E_HIGH (1),
        .MIN_GAP    (2),
        .CNT_W      (8)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .lcd            (bus),
        .oByte          (oByte),
        .oByteIsData    (oByteIsData),
        .oByteValid     (oByteValid),
        .oInitDone      (oInitDone),
        .oByteCount     (oByteCount),
        .oTimingError   (oTimingError),
        .oSequenceError (oSequenceError)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       rs_hi;
        logic       rs_lo;
        int         gap_mid;
        logic       exp_pulse;
        logic [7:0] exp_byte;
        logic       exp_data;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one strobe: E is high for 'high' cycles, then low for 'gap' cycles.
    // 'pulse' is oByteValid one cycle after the fall; 'pulses' counts valid cycles during the gap.
    task automatic strobe(input logic [3:0] nib, input logic rs, input logic rw, input int high,
                          input int gap, output logic pulse, output int pulses);
        bus.iLCD_Data           = nib;
        bus.iLCD_RegisterSelect = rs;
        bus.iLCD_ReadWrite      = rw;
        bus.iLCD_Enabled        = 1'b1;
        repeat (high) tick();
        bus.iLCD_Enabled = 1'b0;
        tick();
        pulse  = oByteValid;
        pulses = int'(oByteValid);
        for (int i = 1; i < gap; i++) begin
            tick();
            pulses += int'(oByteValid);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_byte"}, 32'(oByte), 32'h0);
        chk({tag, "_isdata"}, 32'(oByteIsData), 32'h0);
        chk({tag, "_valid"}, 32'(oByteValid), 32'h0);
        chk({tag, "_init"}, 32'(oInitDone), 32'h0);
        chk({tag, "_count"}, 32'(oByteCount), 32'h0);
        chk({tag, "_terr"}, 32'(oTimingError), 32'h0);
        chk({tag, "_serr"}, 32'(oSequenceError), 32'h0);
    endtask

    task automatic sync(input int extra_threes);
        logic p;
        int   n;
        for (int i = 0; i < 3 + extra_threes; i++) strobe(4'h3, 1'b0, 1'b0, 1, 20, p, n);
        chk("sync_init_before_last", 32'(oInitDone), 32'h0);
        strobe(4'h2, 1'b0, 1'b0, 1, 20, p, n);
        chk("sync_init_done", 32'(oInitDone), 32'h1);
        chk("sync_no_pulse", 32'(n), 32'h0);
    endtask

    initial begin
        logic p;
        int   n;
        int   exp_count;

        vecs[0] = '{4'h2, 4'h8, 1'b0, 1'b0, 20, 1'b1, 8'h28, 1'b0, 1'b0};
        vecs[1] = '{4'h0, 4'hC, 1'b0, 1'b0,  3, 1'b1, 8'h0C, 1'b0, 1'b0};
        vecs[2] = '{4'h0, 4'hE, 1'b0, 1'b0, 20, 1'b1, 8'h0E, 1'b0, 1'b0};
        vecs[3] = '{4'h0, 4'h1, 1'b0, 1'b0, 20, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{4'h4, 4'h1, 1'b1, 1'b1, 20, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[5] = '{4'h5, 4'h5, 1'b0, 1'b1, 20, 1'b0, 8'h41, 1'b1, 1'b1};
        vecs[6] = '{4'h3, 4'h0, 1'b0, 1'b0, 20, 1'b1, 8'h30, 1'b0, 1'b1};

        bus.iLCD_Enabled        = 1'b0;
        bus.iLCD_RegisterSelect = 1'b0;
        bus.iLCD_ReadWrite      = 1'b0;
        bus.iLCD_Data           = 4'h0;
        do_reset();
        chk_all_zero("reset");
        tick();

        // Sync, then send the table of byte pairs.
        sync(0);
        chk("sync_serr", 32'(oSequenceError), 32'h0);
        exp_count = 0;
        for (int v = 0; v < 7; v++) begin
            strobe(vecs[v].hi, vecs[v].rs_hi, 1'b0, 1, vecs[v].gap_mid, p, n);
            chk($sformatf("v%0d_hi_no_pulse", v), 32'(n), 32'h0);
            strobe(vecs[v].lo, vecs[v].rs_lo, 1'b0, 1, 20, p, n);
            if (vecs[v].exp_pulse) exp_count++;
            chk($sformatf("v%0d_pulse", v), 32'(p), 32'(vecs[v].exp_pulse));
            chk($sformatf("v%0d_pulse_len", v), 32'(n), 32'(vecs[v].exp_pulse));
            chk($sformatf("v%0d_byte", v), 32'(oByte), 32'(vecs[v].exp_byte));
            chk($sformatf("v%0d_isdata", v), 32'(oByteIsData), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_count", v), 32'(oByteCount), 32'(exp_count));
            chk($sformatf("v%0d_serr", v), 32'(oSequenceError), 32'(vecs[v].exp_serr));
            chk($sformatf("v%0d_terr", v), 32'(oTimingError), 32'h0);
        end

        // E low for two cycles gives a gap count of 1, below MIN_GAP. The byte is still assembled.
        strobe(4'h6, 1'b1, 1'b0, 1, 2, p, n);
        chk("t5_terr_before_rise", 32'(oTimingError), 32'h0);
        strobe(4'h7, 1'b1, 1'b0, 1, 20, p, n);
        chk("t5_terr", 32'(oTimingError), 32'h1);
        chk("t5_pulse", 32'(p), 32'h1);
        chk("t5_byte", 32'(oByte), 32'h67);
        chk("t5_count", 32'(oByteCount), 32'h7);

        // Reset while E is high with a non-sync nibble: the trailing fall must be ignored.
        bus.iLCD_Data           = 4'h5;
        bus.iLCD_RegisterSelect = 1'b0;
        bus.iLCD_Enabled        = 1'b1;
        do_reset();
        chk_all_zero("rst_e_high");
        tick();
        tick();
        bus.iLCD_Enabled = 1'b0;
        repeat (5) tick();
        chk("rst_e_high_fall_serr", 32'(oSequenceError), 32'h0);
        chk("rst_e_high_fall_terr", 32'(oTimingError), 32'h0);

        // An extra 0x3 during sync is tolerated.
        sync(2);
        chk("extra3_serr", 32'(oSequenceError), 32'h0);

        // A strobe with RW=1 is discarded. The following pair must still be aligned as a byte.
        strobe(4'h9, 1'b0, 1'b1, 1, 20, p, n);
        chk("rw_serr", 32'(oSequenceError), 32'h1);
        chk("rw_no_pulse", 32'(n), 32'h0);
        strobe(4'h1, 1'b0, 1'b0, 1, 20, p, n);
        chk("rw_after_hi_no_pulse", 32'(n), 32'h0);
        strobe(4'h2, 1'b0, 1'b0, 1, 20, p, n);
        chk("rw_after_pulse", 32'(p), 32'h1);
        chk("rw_after_byte", 32'(oByte), 32'h12);
        chk("rw_after_count", 32'(oByteCount), 32'h1);
        chk("rw_init_kept", 32'(oInitDone), 32'h1);

        // Reset in the middle of a pair clears everything. A bad sync nibble is then an error.
        strobe(4'h7, 1'b0, 1'b0, 1, 20, p, n);
        do_reset();
        chk_all_zero("rst_mid_pair");
        tick();
        strobe(4'h3, 1'b0, 1'b0, 1, 20, p, n);
        chk("bad_sync_first_ok", 32'(oSequenceError), 32'h0);
        strobe(4'h5, 1'b0, 1'b0, 1, 20, p, n);
        chk("bad_sync_serr", 32'(oSequenceError), 32'h1);
        chk("bad_sync_init", 32'(oInitDone), 32'h0);
        sync(0);
        strobe(4'hA, 1'b1, 1'b0, 1, 20, p, n);
        strobe(4'hB, 1'b1, 1'b0, 1, 20, p, n);
        chk("resync_byte", 32'(oByte), 32'hAB);
        chk("resync_isdata", 32'(oByteIsData), 32'h1);
        chk("resync_count", 32'(oByteCount), 32'h1);
        chk("resync_serr_sticky", 32'(oSequenceError), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
